// File: rtl/vga_timing_pkg.sv
// XGA 1024x768 raster timing constants and the delay-line stage layout shared by the VGA scan-out block.
// The TEST_PATTERN_EN colour-bar option is resolved in vga_scan_out; this package only supplies the bar colour helper.
package vga_timing_pkg;

    localparam int H_ACTIVE   = 1024;
    localparam int H_FP       = 24;
    localparam int H_SYNC     = 136;
    localparam int H_BP       = 160;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE   = 768;
    localparam int V_FP       = 3;
    localparam int V_SYNC     = 6;
    localparam int V_BP       = 29;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulses occupy [start, end) in raster coordinates.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int PIPE_DELAY = 4;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank;
    } dl_stage_t;

    localparam dl_stage_t DL_STAGE_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank: 1'b1};

    // Bar index bit0 lights blue, bit1 green, bit2 red.
    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that carries per-coordinate control bits alongside the draw pipeline.
// Every stage resets to RST_VAL so the output is a defined idle value until real data has walked through.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// Raster counter and DAC output stage: issues coordinates to the draw blocks and re-aligns syncs/blank to returned pixels.
// Optional macro TEST_PATTERN_EN replaces the pixel input with eight vertical colour bars from the delayed hcount[9:7].
module vga_scan_out #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        blank,
    input  logic [23:0] pixel,
    output logic        frame_tick,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync_n,
    output logic        vga_vsync_n,
    output logic        vga_blank_n
);
    import vga_timing_pkg::*;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef TEST_PATTERN_EN
    localparam int DL_W = $bits(dl_stage_t) + 3;
    localparam logic [DL_W-1:0] DL_RST = {3'b000, DL_STAGE_IDLE};
`else
    localparam int DL_W = $bits(dl_stage_t);
    localparam logic [DL_W-1:0] DL_RST = DL_STAGE_IDLE;
`endif

    logic [10:0]     h_nxt;
    logic [9:0]      v_nxt;
    dl_stage_t       stage_in;
    dl_stage_t       stage_out;
    logic [DL_W-1:0] dl_in;
    logic [DL_W-1:0] dl_out;
    logic [23:0]     colour;

    always_comb begin
        h_nxt = hcount + 11'd1;
        v_nxt = vcount;
        if (hcount == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end
    end

    // blank and frame_tick come from the next coordinate so they switch on the same edge as the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount     <= '0;
            vcount     <= '0;
            blank      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hcount     <= h_nxt;
            vcount     <= v_nxt;
            blank      <= (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
            frame_tick <= (h_nxt == 11'd0) && (v_nxt == V_ACT);
        end
    end

    always_comb begin
        stage_in.hsync_n = !((hcount >= HS_BEG) && (hcount < HS_END));
        stage_in.vsync_n = !((vcount >= VS_BEG) && (vcount < VS_END));
        stage_in.blank   = blank;
    end

`ifdef TEST_PATTERN_EN
    logic [2:0] bar_dly;
    logic       unused_pixel;

    assign dl_in               = {hcount[9:7], stage_in};
    assign {bar_dly, stage_out} = dl_out;
    assign colour              = bar_colour(bar_dly);
    assign unused_pixel        = ^pixel;
`else
    assign dl_in     = stage_in;
    assign stage_out = dl_out;
    assign colour    = pixel;
`endif

    sync_delay_line #(
        .WIDTH   (DL_W),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (DL_RST)
    ) u_sync_delay_line (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (dl_in),
        .q       (dl_out)
    );

    // Async reset here is what kills a sync pulse in flight the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync_n <= 1'b1;
            vga_vsync_n <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= stage_out.blank ? 24'h000000 : colour;
            vga_hsync_n           <= stage_out.hsync_n;
            vga_vsync_n           <= stage_out.vsync_n;
            vga_blank_n           <= !stage_out.blank;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench: XGA instance checked against a hand-computed vector table, two reduced-raster instances
// (pipeline depth 2 and 7) checked every cycle against expected coordinates, plus hsync and mid-frame reset sequences.
module tb_vga_scan_out;

    localparam int XP   = 4;
    localparam int XHT  = 1344;
    localparam int SHT  = 24;
    localparam int SVT  = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [10:0] x_h;   logic [9:0] x_v;   logic x_blank, x_tick;
    logic [23:0] x_pix; logic [7:0] x_r, x_g, x_b; logic x_hs, x_vs, x_bn;
    logic [10:0] a_h;   logic [9:0] a_v;   logic a_blank, a_tick;
    logic [23:0] a_pix; logic [7:0] a_r, a_g, a_b; logic a_hs, a_vs, a_bn;
    logic [10:0] b_h;   logic [9:0] b_v;   logic b_blank, b_tick;
    logic [23:0] b_pix; logic [7:0] b_r, b_g, b_b; logic b_hs, b_vs, b_bn;

    vga_scan_out u_xga (
        .clk(clk), .reset_n(reset_n), .hcount(x_h), .vcount(x_v), .blank(x_blank),
        .pixel(x_pix), .frame_tick(x_tick), .vga_r(x_r), .vga_g(x_g), .vga_b(x_b),
        .vga_hsync_n(x_hs), .vga_vsync_n(x_vs), .vga_blank_n(x_bn)
    );

    vga_scan_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(2)
    ) u_small_p2 (
        .clk(clk), .reset_n(reset_n), .hcount(a_h), .vcount(a_v), .blank(a_blank),
        .pixel(a_pix), .frame_tick(a_tick), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync_n(a_hs), .vga_vsync_n(a_vs), .vga_blank_n(a_bn)
    );

    vga_scan_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(7)
    ) u_small_p7 (
        .clk(clk), .reset_n(reset_n), .hcount(b_h), .vcount(b_v), .blank(b_blank),
        .pixel(b_pix), .frame_tick(b_tick), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hsync_n(b_hs), .vga_vsync_n(b_vs), .vga_blank_n(b_bn)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
    } vec_t;

    vec_t tbl[12];

    int e_cur;
    int hs_prev, low_len, last_fall;
    int tick_first, tick_second;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] pack_coord(input int h, input int v);
        return {3'b000, 11'(h), 10'(v)};
    endfunction

    function automatic logic [23:0] colour_of(input int h, input logic [23:0] pix);
        logic [10:0] hv;
        hv = 11'(h);
`ifdef TEST_PATTERN_EN
        return {{8{hv[9]}}, {8{hv[8]}}, {8{hv[7]}}};
`else
        if (hv == 11'h7ff) return 24'h0;
        return pix;
`endif
    endfunction

    task automatic drive_pixels(input int e);
        x_pix = 24'h123456;
        a_pix = (e - 2 >= 0) ? pack_coord((e - 2) % SHT, ((e - 2) / SHT) % SVT) : 24'hABCDEF;
        b_pix = (e - 7 >= 0) ? pack_coord((e - 7) % SHT, ((e - 7) / SHT) % SVT) : 24'hABCDEF;
    endtask

    task automatic check_small(input string tag, input int p, input int e,
                               input logic [10:0] h, input logic [9:0] v, input logic bl, input logic tk,
                               input logic [23:0] rgb, input logic hs, input logic vs, input logic bn);
        int ch, cv, c;
        logic eb;
        logic [23:0] er;
        ch = e % SHT;
        cv = (e / SHT) % SVT;
        check({tag, "_hcount"}, 32'(h), 32'(ch));
        check({tag, "_vcount"}, 32'(v), 32'(cv));
        check({tag, "_blank"}, 32'(bl), 32'((ch >= 16) || (cv >= 6)));
        check({tag, "_frame_tick"}, 32'(tk), 32'((ch == 0) && (cv == 6)));
        c = e - p - 1;
        if (c < 0) begin
            check({tag, "_rgb_idle"}, 32'(rgb), 32'h0);
            check({tag, "_hsync_idle"}, 32'(hs), 32'h1);
            check({tag, "_vsync_idle"}, 32'(vs), 32'h1);
            check({tag, "_blank_n_idle"}, 32'(bn), 32'h0);
        end else begin
            ch = c % SHT;
            cv = (c / SHT) % SVT;
            eb = (ch >= 16) || (cv >= 6);
            er = eb ? 24'h0 : colour_of(ch, pack_coord(ch, cv));
            check({tag, "_rgb"}, 32'(rgb), 32'(er));
            check({tag, "_hsync_n"}, 32'(hs), 32'(!((ch >= 18) && (ch < 21))));
            check({tag, "_vsync_n"}, 32'(vs), 32'(!((cv >= 7) && (cv < 9))));
            check({tag, "_blank_n"}, 32'(bn), 32'(!eb));
        end
    endtask

    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            e_cur++;
            #1;
            for (int i = 0; i < 12; i++) begin
                if (e_cur == tbl[i].v * XHT + tbl[i].h + XP + 1) begin
                    check({tbl[i].name, "_rgb"}, 32'({x_r, x_g, x_b}),
                          32'(tbl[i].bn ? colour_of(tbl[i].h, tbl[i].rgb) : 24'h0));
                    check({tbl[i].name, "_hsync_n"}, 32'(x_hs), 32'(tbl[i].hs));
                    check({tbl[i].name, "_vsync_n"}, 32'(x_vs), 32'(tbl[i].vs));
                    check({tbl[i].name, "_blank_n"}, 32'(x_bn), 32'(tbl[i].bn));
                end
            end
            check("xga_hcount", 32'(x_h), 32'(e_cur % XHT));
            check("xga_vcount", 32'(x_v), 32'(e_cur / XHT));
            if (hs_prev == 1 && x_hs == 1'b0) begin
                if (last_fall < 0) check("xga_hsync_first_fall", 32'(e_cur), 32'(1048 + XP + 1));
                else               check("xga_hsync_period", 32'(e_cur - last_fall), 32'(XHT));
                last_fall = e_cur;
                low_len   = 0;
            end
            if (x_hs == 1'b0) low_len++;
            if (hs_prev == 0 && x_hs == 1'b1) check("xga_hsync_width", 32'(low_len), 32'd136);
            hs_prev = int'(x_hs);
            if (a_tick) begin
                if (tick_first < 0) tick_first = e_cur;
                else if (tick_second < 0) tick_second = e_cur;
            end
            check_small("p2", 2, e_cur, a_h, a_v, a_blank, a_tick, {a_r, a_g, a_b}, a_hs, a_vs, a_bn);
            check_small("p7", 7, e_cur, b_h, b_v, b_blank, b_tick, {b_r, b_g, b_b}, b_hs, b_vs, b_bn);
            drive_pixels(e_cur);
        end
    endtask

    task automatic start_phase();
        e_cur       = 0;
        hs_prev     = 1;
        low_len     = 0;
        last_fall   = -1;
        tick_first  = -1;
        tick_second = -1;
        drive_pixels(0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xga_hcount"}, 32'(x_h), 32'h0);
        check({tag, "_xga_vcount"}, 32'(x_v), 32'h0);
        check({tag, "_xga_blank"}, 32'(x_blank), 32'h0);
        check({tag, "_xga_frame_tick"}, 32'(x_tick), 32'h0);
        check({tag, "_xga_rgb"}, 32'({x_r, x_g, x_b}), 32'h0);
        check({tag, "_xga_hsync_n"}, 32'(x_hs), 32'h1);
        check({tag, "_xga_vsync_n"}, 32'(x_vs), 32'h1);
        check({tag, "_xga_blank_n"}, 32'(x_bn), 32'h0);
        check({tag, "_p2_out"}, 32'({a_r, a_g, a_b, a_hs, a_vs, a_bn}), 32'({24'h0, 3'b110}));
        check({tag, "_p7_out"}, 32'({b_r, b_g, b_b, b_hs, b_vs, b_bn}), 32'({24'h0, 3'b110}));
    endtask

    initial begin
        tbl[0]  = '{"act_first",    0,    0, 24'h123456, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{"act_last",     1023, 0, 24'h123456, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{"fp_first",     1024, 0, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{"fp_last",      1047, 0, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{"hs_first",     1048, 0, 24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{"hs_last",      1183, 0, 24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{"bp_first",     1184, 0, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{"line_end",     1343, 0, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{"line1_first",  0,    1, 24'h123456, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{"line1_bar1",   200,  1, 24'h123456, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{"line1_hs",     1048, 1, 24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{"line2_mid",    700,  2, 24'h123456, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0;
        x_pix = 24'h0;
        a_pix = 24'h0;
        b_pix = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        @(negedge clk);
        reset_n = 1'b1;
        start_phase();
        run_edges(3 * XHT + 1100);
        check("p2_tick_first", 32'(tick_first), 32'(6 * SHT));
        check("p2_tick_second", 32'(tick_second), 32'(6 * SHT + SHT * SVT));

        // Mid-line reset while the XGA hsync output is low.
        check("pre_reset_xga_hcount", 32'(x_h), 32'd1100);
        check("pre_reset_xga_hsync_n", 32'(x_hs), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        start_phase();
        run_edges(400);
        check("restart_tick_first", 32'(tick_first), 32'(6 * SHT));
        check("restart_tick_second", 32'(tick_second), 32'(6 * SHT + SHT * SVT));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Display-side end of the sprite pixel interface.
- Generates the raster coordinates hcount/vcount/blank that sprite and draw blocks consume.
- Takes back the 24-bit pixel those blocks return after a fixed pipeline latency.
- Re-aligns syncs and blanking to that latency, and drives registered RGB, sync and blank to the VGA DAC. Also emits a once-per-frame tick for game-state update during vertical blank.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks); H_TOTAL = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = 806
- PIPE_DELAY, 4, cycles from hcount/vcount issue to matching pixel valid at the pixel input; legal range 1..15

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hcount  out  11  current horizontal position, to draw blocks
- vcount  out  10  current vertical position, to draw blocks
- blank  out  1  high outside the active area, same cycle as hcount/vcount
- pixel  in  24  {R[23:16],G[15:8],B[7:0]} from draw blocks, valid PIPE_DELAY cycles after its coordinate
- frame_tick  out  1  one-cycle pulse at start of vertical blank
- vga_r, vga_g, vga_b  out  8 each  registered colour to DAC
- vga_hsync_n  out  1  active-low hsync, aligned with vga_r/g/b
- vga_vsync_n  out  1  active-low vsync, aligned with vga_r/g/b
- vga_blank_n  out  1  active-low blank, aligned with vga_r/g/b

Behaviour:
- Reset is asynchronous active-low: clk and reset_n only, no synchronous clear. While reset_n=0:
  - hcount=0, vcount=0, blank=0, frame_tick=0
  - vga_r/g/b=0, vga_hsync_n=1, vga_vsync_n=1, vga_blank_n=0
  - every delay-line stage is loaded with {hsync_n=1, vsync_n=1, blank=1}
- Counters:
  - hcount increments every clk.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0.
  - The counters never hold values ≥ the totals.
- blank = (hcount ≥ H_ACTIVE) | (vcount ≥ V_ACTIVE). It is registered so it changes on the same edge as the counters, with no combinational path to the outputs.
- Raw syncs, computed for the same coordinate:
  - hsync_raw_n = 0 iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC
  - vsync_raw_n = 0 iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC
- frame_tick is high for exactly one cycle, the cycle where hcount=0 and vcount=V_ACTIVE. It is issued with the coordinates, not delayed.
- Alignment:
  - {hsync_raw_n, vsync_raw_n, blank} for the coordinate issued at cycle t enters a PIPE_DELAY-deep shift register.
  - At t+PIPE_DELAY the pixel input belongs to that coordinate. On that edge the output register captures:
    - vga_r/g/b = delayed blank ? 0 : pixel
    - vga_hsync_n, vga_vsync_n = delayed values
    - vga_blank_n = ~delayed blank
  - Total latency from coordinate to DAC pins is PIPE_DELAY+1 cycles.
- The pixel input is ignored (forced black) whenever the delayed blank is set. Draw blocks may drive any value there.
- After reset release, the first PIPE_DELAY+1 output cycles show the reset-loaded inactive stage values (black, syncs high). Real coordinate-(0,0) data appears at the output on the (PIPE_DELAY+1)th edge after release.
- Reset mid-frame: the counters return to (0,0) immediately. The outputs force the reset values asynchronously, so no partial sync pulse is emitted after reset assertion.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined: the pixel input is ignored. Colour is 8 vertical bars, each H_ACTIVE/8 wide, derived from the delayed hcount[9:7]. Bit0 gives B=FF, bit1 gives G=FF, bit2 gives R=FF; bar 0 is black, bar 7 is white. Blanking still forces black.
  - Requires hcount[9:7] in the delay line, widening it by 3 bits.
- Undefined: normal behaviour, with no extra delay-line bits.

Decomposition:
- Package vga_timing_pkg holds:
  - the XGA timing constants listed above
  - derived H_TOTAL/V_TOTAL
  - sync start/end localparams
  - a packed struct {hsync_n, vsync_n, blank} for delay-line stages
- One sub-module, sync_delay_line: parameterised width/depth shift register with async active-low reset to a parameter reset value. It is instantiated once.

Test Plan:
- Reset then 2 full frames → hcount spans 0..1343 and vcount spans 0..805; exactly 2 frame_tick pulses, each at (0,768); period 1,083,264 clocks.
- Hsync timing, sampled at the output → vga_hsync_n low for exactly 136 clocks; low starts PIPE_DELAY+1 clocks after hcount=1048 is issued; period 1344 clocks.
- Vsync timing → vga_vsync_n low for 6 lines (8064 clocks), starting with the line at vcount=771.
- pixel=24'h123456 held constant → vga_r/g/b = 12/34/56 only where vga_blank_n=1. The first non-black pixel of the line appears PIPE_DELAY+1 clocks after hcount=0. Exactly 1024 non-black pixels per active line, none for vcount ≥ 768.
- Latency check: drive pixel = {hcount,vcount} delayed by PIPE_DELAY in the bench, with PIPE_DELAY overridden to 2 and 7 → the output always matches the coordinate issued PIPE_DELAY+1 cycles earlier.
- Assert reset_n=0 at hcount=1100, vcount=400 → the same cycle shows syncs high, RGB 0, blank_n 0. After release, hcount restarts 0 and the first frame_tick occurs 768×1344 clocks later. Repeat with TEST_PATTERN_EN defined → bar at hcount 128..255 reads 0000FF.
